// File: rtl/ddr_init_seq.sv
// Multi-channel DDR bring-up sequencer: reset pulse, calibration wait with timeout, retries.
// Optional compare-error capture is built when DDR_INIT_CMP_ERR_EN is defined.
module ddr_init_seq #(
   parameter int CH_NUM     = 2,
   parameter int RST_CYCLES = 16,
   parameter int TIMEOUT    = 65536,
   parameter int MAX_RETRY  = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              clear_err,
   input  logic [CH_NUM-1:0] calib_done,
   input  logic [CH_NUM-1:0] cmp_err,
   output logic [CH_NUM-1:0] ddr_rst,
   output logic              busy,
   output logic              all_ready,
   output logic              fail,
   output logic [CH_NUM-1:0] fail_mask,
   output logic [3:0]        retry_cnt,
   output logic [CH_NUM-1:0] err_sticky
);

   localparam int CNT_MAX = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX);
   localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] TO_LAST   = CNT_W'(TIMEOUT - 1);
   localparam logic [3:0]       RETRY_LIM = 4'(MAX_RETRY);

   typedef enum logic [2:0] {IDLE, RESET, WAIT, READY, FAIL} state_t;

   state_t            state_reg, state_next;
   logic [CNT_W-1:0]  cnt_reg;
   logic [CH_NUM-1:0] calib_s1_reg, calib_s_reg;
   logic [3:0]        retry_reg;
   logic [CH_NUM-1:0] fail_mask_reg;
   logic [CH_NUM-1:0] err_set;
   logic [CH_NUM-1:0] err_sticky_reg;
   logic              calib_all;
   logic              tmo_ev;
   logic              restart;

   assign calib_all = &calib_s_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_reg <= IDLE;
      else        state_reg <= state_next;
   end

   // A lost calibration in READY is handled exactly like a WAIT timeout.
   always_comb begin
      state_next = state_reg;
      tmo_ev     = 1'b0;
      restart    = 1'b0;
      case (state_reg)
         IDLE, FAIL: begin
            if (start) begin
               state_next = RESET;
               restart    = 1'b1;
            end
         end
         RESET: if (cnt_reg == RST_LAST) state_next = WAIT;
         WAIT: begin
            if (calib_all)                state_next = READY;
            else if (cnt_reg == TO_LAST)  tmo_ev     = 1'b1;
         end
         READY: if (!calib_all) tmo_ev = 1'b1;
         default: state_next = IDLE;
      endcase
      if (tmo_ev) state_next = (retry_reg < RETRY_LIM) ? RESET : FAIL;
   end

   always_comb begin
      ddr_rst   = {CH_NUM{(state_reg == RESET) || !rst_n}};
      busy      = (state_reg == RESET) || (state_reg == WAIT);
      all_ready = (state_reg == READY);
      fail      = (state_reg == FAIL);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         calib_s1_reg  <= '0;
         calib_s_reg   <= '0;
         cnt_reg       <= '0;
         retry_reg     <= '0;
         fail_mask_reg <= '0;
      end else begin
         calib_s1_reg <= calib_done;
         calib_s_reg  <= calib_s1_reg;

         if ((state_next != state_reg) || !((state_reg == RESET) || (state_reg == WAIT)))
            cnt_reg <= '0;
         else
            cnt_reg <= cnt_reg + CNT_W'(1);

         if (restart)
            retry_reg <= '0;
         else if (tmo_ev && (retry_reg < RETRY_LIM))
            retry_reg <= retry_reg + 4'd1;

         if (restart)
            fail_mask_reg <= '0;
         else if (tmo_ev)
            fail_mask_reg <= ~calib_s_reg;
         else if (state_reg == READY)
            fail_mask_reg <= fail_mask_reg | err_set;
      end
   end

`ifdef DDR_INIT_CMP_ERR_EN
   logic [CH_NUM-1:0] err_s1_reg, err_s_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_s1_reg <= '0;
         err_s_reg  <= '0;
      end else begin
         err_s1_reg <= cmp_err;
         err_s_reg  <= err_s1_reg;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < CH_NUM; gi++) begin : g_err
         logic sticky_reg;
         assign err_set[gi] = (state_reg == READY) && err_s_reg[gi];
         // A set in the same cycle as clear_err wins.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)            sticky_reg <= 1'b0;
            else if (err_set[gi])  sticky_reg <= 1'b1;
            else if (clear_err)    sticky_reg <= 1'b0;
         end
         assign err_sticky_reg[gi] = sticky_reg;
      end
   endgenerate
`else
   logic unused_err_in;
   assign unused_err_in  = ^{cmp_err, clear_err};
   assign err_set        = '0;
   assign err_sticky_reg = '0;
`endif

   assign fail_mask  = fail_mask_reg;
   assign retry_cnt  = retry_reg;
   assign err_sticky = err_sticky_reg;

endmodule

// File: tb/tb_ddr_init_seq.sv
// Bench for ddr_init_seq: randomized bring-up runs checked against a timeline model,
// plus directed error-capture, calibration-loss and mid-operation reset steps.
module tb_ddr_init_seq;
   localparam int CH = 2;
   localparam int R  = 4;
   localparam int T  = 32;
   localparam int M  = 2;
   localparam int P  = R + T;

   logic          clk = 1'b0;
   logic          rst_n, start, clear_err;
   logic [CH-1:0] calib_done, cmp_err;
   logic [CH-1:0] ddr_rst, fail_mask, err_sticky;
   logic          busy, all_ready, fail;
   logic [3:0]    retry_cnt;

   int n_assert = 0;
   int n_fail   = 0;
   int edge_cnt = 0;

   // timeline of the current run: start edge, successful attempt, READY edge
   int run_s, run_k, run_rdy;

   ddr_init_seq #(.CH_NUM(CH), .RST_CYCLES(R), .TIMEOUT(T), .MAX_RETRY(M)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .clear_err(clear_err),
      .calib_done(calib_done), .cmp_err(cmp_err), .ddr_rst(ddr_rst),
      .busy(busy), .all_ready(all_ready), .fail(fail), .fail_mask(fail_mask),
      .retry_cnt(retry_cnt), .err_sticky(err_sticky)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, obs, exp, edge_cnt);
      end
   endtask

   // Inputs set after tick() are sampled on the following rising edge.
   task automatic tick();
      @(posedge clk);
      edge_cnt++;
      @(negedge clk);
   endtask

   // Phase after edge e: 0 idle, 1 reset, 2 wait, 3 ready, 4 fail; rc = retries used.
   function automatic void model(input int e, output int ph, output int rc);
      int off, a;
      if (e < run_s) begin
         ph = 0; rc = 0;
      end else if (run_rdy >= 0 && e >= run_rdy) begin
         ph = 3; rc = run_k;
      end else begin
         off = e - run_s;
         a   = off / P;
         if (a > M) begin
            ph = 4; rc = M;
         end else begin
            ph = ((off % P) < R) ? 1 : 2;
            rc = a;
         end
      end
   endfunction

   task automatic do_reset();
      rst_n = 1'b0; start = 1'b0; clear_err = 1'b0; cmp_err = '0; calib_done = '0;
      repeat (3) tick();
      chk("rst_ddr_rst",    ddr_rst,    2'b11);
      chk("rst_busy",       busy,       0);
      chk("rst_all_ready",  all_ready,  0);
      chk("rst_fail",       fail,       0);
      chk("rst_fail_mask",  fail_mask,  0);
      chk("rst_retry_cnt",  retry_cnt,  0);
      chk("rst_err_sticky", err_sticky, 0);
      rst_n = 1'b1;
      tick();
      chk("idle_ddr_rst", ddr_rst, 0);
      chk("idle_busy",    busy,    0);
   endtask

   initial begin
      int k_tab[3]   = '{0, 1, M + 1};
      int sub_tab[3] = '{0, 1, 2};
      int k, o, subset, c_edge, end_e, ph, rc, exp_fm;

      rst_n = 1'b0; start = 1'b0; clear_err = 1'b0; cmp_err = '0; calib_done = '0;
      tick();

      for (int run = 0; run < 7; run++) begin
         do_reset();
         k      = (run < 3) ? k_tab[run]   : int'($urandom_range(0, M + 1));
         subset = (run < 3) ? sub_tab[run] : int'($urandom_range(0, 2));
         o      = int'($urandom_range(0, T - 1));
         $display("run %0d: success attempt %0d, offset %0d, early channels %b", run, k, o, subset[1:0]);

         start      = 1'b1;
         calib_done = subset[CH-1:0];
         run_s      = edge_cnt + 1;
         run_k      = k;
         if (k <= M) begin
            c_edge  = run_s + k * P + R + o - 1;
            run_rdy = c_edge + 2;
            end_e   = run_rdy + 5;
         end else begin
            c_edge  = -1;
            run_rdy = -1;
            end_e   = run_s + (M + 1) * P + 5;
         end

         while (edge_cnt < end_e) begin
            tick();
            start = 1'b0;
            if (edge_cnt + 1 == c_edge) calib_done = 2'b11;
            model(edge_cnt, ph, rc);
            exp_fm = ((ph == 4) || (rc > 0)) ? (~subset & 3) : 0;
            chk("run_ddr_rst",   ddr_rst,   (ph == 1) ? 3 : 0);
            chk("run_busy",      busy,      (ph == 1 || ph == 2) ? 1 : 0);
            chk("run_all_ready", all_ready, (ph == 3) ? 1 : 0);
            chk("run_fail",      fail,      (ph == 4) ? 1 : 0);
            chk("run_retry_cnt", retry_cnt, rc);
            chk("run_fail_mask", fail_mask, exp_fm);
         end

         if (k > M) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            chk("restart_fail",      fail,      0);
            chk("restart_retry_cnt", retry_cnt, 0);
            chk("restart_ddr_rst",   ddr_rst,   2'b11);
            chk("restart_fail_mask", fail_mask, 0);
            chk("restart_busy",      busy,      1);
         end
      end

      // Directed: bring-up with calibration already present
      do_reset();
      calib_done = 2'b11;
      start = 1'b1;
      tick();
      start = 1'b0;
      repeat (R) tick();
      chk("dir_not_ready_yet", all_ready, 0);
      tick();
      chk("dir_ready",     all_ready, 1);
      chk("dir_retry_cnt", retry_cnt, 0);

      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_in_ready_ignored", all_ready, 1);
      chk("start_in_ready_ddr_rst", ddr_rst,   0);

`ifdef DDR_INIT_CMP_ERR_EN
      cmp_err = 2'b01;
      tick();
      cmp_err = '0;
      chk("err_sync_lat0", err_sticky, 0);
      tick();
      chk("err_sync_lat1", err_sticky, 0);
      tick();
      chk("err_set", err_sticky, 2'b01);
      repeat (3) tick();
      chk("err_persist",   err_sticky, 2'b01);
      chk("err_fail_mask", fail_mask,  2'b01);
      chk("err_in_ready",  all_ready,  1);
      cmp_err = 2'b01;
      tick();
      cmp_err = '0;
      tick();
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk("err_set_beats_clear", err_sticky, 2'b01);
      clear_err = 1'b1;
      tick();
      clear_err = 1'b0;
      chk("err_clear", err_sticky, 0);
`else
      cmp_err   = 2'b11;
      clear_err = 1'b1;
      repeat (4) tick();
      cmp_err   = '0;
      clear_err = 1'b0;
      chk("err_off_sticky",    err_sticky, 0);
      chk("err_off_fail_mask", fail_mask,  0);
`endif

      // Calibration loss on ch1 while READY
      calib_done = 2'b01;
      tick();
      chk("loss_ready_d0", all_ready, 1);
      tick();
      chk("loss_ready_d1", all_ready, 1);
      chk("loss_ddr_rst_d1", ddr_rst, 0);
      tick();
      chk("loss_ddr_rst",   ddr_rst,   2'b11);
      chk("loss_retry_cnt", retry_cnt, 1);
      chk("loss_fail_mask", fail_mask, 2'b10);
      chk("loss_busy",      busy,      1);
      repeat (R) tick();
      chk("wait_ddr_rst", ddr_rst, 0);
      chk("wait_busy",    busy,    1);

      // Reset asserted mid-cycle during WAIT acts at once
      #2 rst_n = 1'b0;
      #1;
      chk("async_ddr_rst",   ddr_rst,   2'b11);
      chk("async_busy",      busy,      0);
      chk("async_retry_cnt", retry_cnt, 0);
      chk("async_fail_mask", fail_mask, 0);
      calib_done = 2'b11;
      tick();
      tick();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk("post_rst_idle_ready", all_ready, 0);
         chk("post_rst_idle_busy",  busy,      0);
         chk("post_rst_ddr_rst",    ddr_rst,   0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
